// File: rtl/sopc4_mem_master.sv
`default_nettype none
// ============================================================================
//  Module   : sopc4_mem_master
//  Purpose  : Avalon-MM block FILL / VERIFY engine for an on-chip memory port.
//  Revision : 1.0 - initial release
// ============================================================================
module sopc4_mem_master #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 17,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic [DATA_W-1:0]     seed,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W-1:0]     readdata,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [DATA_W-1:0]     first_err_data
);

    localparam int                     c_BE_W       = DATA_W / 8;
    localparam logic [ERR_W-1:0]       c_ERR_MAX    = {ERR_W{1'b1}};
    // Every pipeline stage except the last (the one being compared this edge).
    localparam logic [READ_LATENCY-1:0] c_UPPER_MASK = {READ_LATENCY{1'b1}} >> 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                               r_state;
    logic                                 r_mode;
    logic [LEN_W-1:0]                     r_remaining;

    logic [READ_LATENCY-1:0]              r_pv;
    logic [READ_LATENCY-1:0][ADDR_W-1:0]  r_pa;
    logic [READ_LATENCY-1:0][DATA_W-1:0]  r_pd;

    logic                                 w_mismatch;
    logic                                 w_pipe_upper;

    assign byteenable   = {c_BE_W{1'b1}};
    assign w_mismatch   = r_pv[READ_LATENCY-1] && (readdata != r_pd[READ_LATENCY-1]);
    assign w_pipe_upper = |(r_pv & c_UPPER_MASK);

    // Expected word and address follow each read until its data returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pv <= '0;
            r_pa <= '0;
            r_pd <= '0;
        end else begin
            r_pv[0] <= chipselect & ~write;
            r_pa[0] <= address;
            r_pd[0] <= writedata;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pa[k] <= r_pa[k-1];
                r_pd[k] <= r_pd[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_mode         <= 1'b0;
            r_remaining    <= '0;
            address        <= '0;
            writedata      <= '0;
            chipselect     <= 1'b0;
            write          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            done <= 1'b0;

            if (w_mismatch) begin
                if (err_count != c_ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (err_count == '0) begin
                    first_err_addr <= r_pa[READ_LATENCY-1];
                    first_err_data <= readdata;
                end
            end

            case (r_state)
                S_IDLE: begin
                    // done still high means this is the completion cycle; ignore start.
                    if (start && !done) begin
                        r_mode         <= mode;
                        r_remaining    <= length;
                        address        <= base_addr;
                        writedata      <= seed;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        busy           <= 1'b1;
                        if (length == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state    <= S_RUN;
                            chipselect <= 1'b1;
                            write      <= ~mode;
                        end
                    end
                end
                S_RUN: begin
                    if (r_remaining == LEN_W'(1)) begin
                        chipselect <= 1'b0;
                        write      <= 1'b0;
                        r_state    <= r_mode ? S_DRAIN : S_DONE;
                    end else begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        address     <= address + ADDR_W'(1);
                        writedata   <= writedata + DATA_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!w_pipe_upper) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sopc4_mem_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sopc4_mem_master
//  Purpose  : Self-checking bench for sopc4_mem_master with a memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sopc4_mem_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 17;
    localparam int RL = 1;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic [DW-1:0] seed = '0;
    logic [DW-1:0] readdata = '0;
    logic [AW-1:0] address;
    logic [DW/8-1:0] byteenable;
    logic          chipselect;
    logic          write;
    logic [DW-1:0] writedata;
    logic          busy;
    logic          done;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        logic [3:0]    be;
    } acc_t;
    acc_t acc_q[$];

    logic [DW-1:0] mem [bit [AW-1:0]];

    sopc4_mem_master #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(RL), .ERR_W(EW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(readdata),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // Single-cycle-latency on-chip memory slave.
    always @(posedge clk) begin
        if (chipselect === 1'b1 && write === 1'b1) mem[address] = writedata;
        if (chipselect === 1'b1 && write === 1'b0) readdata <= mem_rd(address);
    end

    always @(negedge clk) begin
        if (chipselect === 1'b1) acc_q.push_back('{cyc, address, write, writedata, byteenable});
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic m, input logic [AW-1:0] b, input logic [LW-1:0] n,
                          input logic [DW-1:0] s, input int poke, input bit poke_done);
        int            t0, exp_done, ne;
        logic [AW-1:0] fa, ea;
        logic [DW-1:0] fd, ed;
        bit            seen;
        ne = 0; fa = '0; fd = '0;
        if (m) begin
            for (int i = 0; i < int'(n); i++) begin
                ea = b + AW'(i);
                ed = s + DW'(i);
                if (mem_rd(ea) !== ed) begin
                    if (ne == 0) begin fa = ea; fd = mem_rd(ea); end
                    ne++;
                end
            end
        end
        exp_done = (n == 0) ? 1 : int'(n) + 1 + (m ? RL : 0);

        @(negedge clk);
        mode = m; base_addr = b; length = n; seed = s; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; start = 1'b0; acc_q.delete(); done_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < int'(n) + 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) check("busy_after_start", busy, 1);
            if (k == poke) begin
                start = 1'b1; mode = ~m; base_addr = ~b; length = LW'(5); seed = ~s;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                check("done_latency", 64'(cyc - t0), 64'(exp_done));
                if (poke_done) start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        if (poke_done) check("start_in_done_ignored", busy, 0);
        repeat (2) @(negedge clk);
        check("done_seen", seen, 1);
        check("done_count", 64'(done_cnt), 1);
        check("busy_end", busy, 0);
        check("access_count", 64'(acc_q.size()), 64'(n));
        for (int i = 0; i < acc_q.size() && i < int'(n); i++) begin
            ea = b + AW'(i);
            ed = s + DW'(i);
            check("acc_addr", acc_q[i].a, ea);
            check("acc_cycle", 64'(acc_q[i].c - t0), 64'(i));
            check("acc_write", acc_q[i].w, !m);
            check("acc_be", acc_q[i].be, 4'hF);
            if (!m) check("acc_wdata", acc_q[i].d, ed);
        end
        if (m) begin
            check("err_count", err_count, 64'(ne));
            check("first_err_addr", first_err_addr, fa);
            check("first_err_data", first_err_data, fd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] rb, ca;
        logic [LW-1:0] rn;
        logic [DW-1:0] rs;

        repeat (2) @(negedge clk);
        check("rst_cs", chipselect, 0);
        check("rst_write", write, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", address, 0);
        check("rst_wdata", writedata, 0);
        check("rst_err", err_count, 0);
        check("rst_ferr_a", first_err_addr, 0);
        check("rst_ferr_d", first_err_data, 0);
        check("rst_be", byteenable, 4'hF);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cs", chipselect, 0);

        run_op(1'b0, 16'h0010, 17'd4, 32'hA5A50000, -1, 1'b0);
        run_op(1'b1, 16'h0010, 17'd4, 32'hA5A50000, -1, 1'b0);
        mem[16'h0012] = '0;
        run_op(1'b1, 16'h0010, 17'd4, 32'hA5A50000, -1, 1'b0);
        run_op(1'b1, 16'h0030, 17'd0, 32'h00000001, -1, 1'b1);
        run_op(1'b0, 16'hFFFE, 17'd3, 32'hFFFFFFFF, -1, 1'b0);
        run_op(1'b1, 16'hFFFE, 17'd3, 32'hFFFFFFFF, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rb = AW'($urandom);
            rn = LW'($urandom_range(1, 24));
            rs = $urandom;
            run_op(1'b0, rb, rn, rs, -1, 1'b0);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                ca = rb + AW'($urandom_range(0, int'(rn) - 1));
                mem[ca] = $urandom;
            end
            run_op(1'b1, rb, rn, rs, -1, 1'b0);
        end

        // A start mid-run and one in the completion cycle must both be ignored.
        run_op(1'b0, 16'h0400, 17'd8, 32'h12345678, 2, 1'b1);

        @(negedge clk);
        mode = 1'b1; base_addr = 16'h0200; length = 17'd10; seed = 32'h0BAD0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; done_cnt = 0;
        @(posedge clk); #1;
        check("cs_before_reset", chipselect, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_cs", chipselect, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_write", write, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt), 0);
        check("idle_after_reset_cs", chipselect, 0);
        check("err_after_reset", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sopc4_mem_master.md
Name: sopc4_mem_master

Overview:
- Avalon-MM master that drives the on-chip memory slave port (32-bit data, 16-bit word address, byteenable, single-cycle fixed read latency, no waitrequest).
- Runs a block operation on a software-supplied address range: FILL writes an incrementing pattern; VERIFY reads it back and compares.
- Sits beside the Nios subsystem as a memory self-test and initialisation engine.
- Control and status are plain registers/pulses, intended for a PIO or CSR wrapper.

Parameters:
ADDR_W, 16, word address width; matches the memory slave address port
DATA_W, 32, data width; byteenable width is DATA_W/8
LEN_W, 17, width of the length field (allows 65536 words)
READ_LATENCY, 1, cycles from read issue edge to valid readdata; legal range 1..4
ERR_W, 16, error counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = FILL, 1 = VERIFY; latched with start
base_addr  in  ADDR_W  first word address; latched with start
length  in  LEN_W  number of words; latched with start
seed  in  DATA_W  pattern for word 0; latched with start
address  out  ADDR_W  to slave address
byteenable  out  DATA_W/8  to slave byteenable
chipselect  out  1  to slave chipselect
write  out  1  to slave write
writedata  out  DATA_W  to slave writedata
readdata  in  DATA_W  from slave readdata
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err_count  out  ERR_W  VERIFY mismatches; saturating
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_data  out  DATA_W  readdata at the first mismatch

Behaviour:
- Reset (asynchronous): state IDLE. address, writedata, first_err_* = 0. chipselect, write, busy, done = 0. err_count = 0. byteenable = all ones at all times.
- All outputs are registered. Pattern for word i = seed + i, modulo 2^DATA_W.
- Address for word i = base_addr + i, modulo 2^ADDR_W. Wrap from all-ones to 0 is legal; there is no bounds check against memory depth.
- IDLE:
  - start=1 latches mode, base, length and seed; clears err_count and first_err_*.
  - length=0: go to DONE (no bus access).
  - Otherwise go to RUN.
  - start while not IDLE is ignored.
- RUN: one access per cycle for exactly `length` consecutive cycles, chipselect=1.
  - FILL: write=1, writedata = pattern(i).
  - VERIFY: write=0.
  - After the last access: FILL goes to DONE; VERIFY goes to DRAIN.
- Compare pipeline (VERIFY): the expected value and address travel through a READ_LATENCY-deep shift register with a valid bit. At the edge READ_LATENCY cycles after issue, readdata is compared with the expected value.
- On mismatch:
  - err_count increments, holding at all ones.
  - If err_count was 0 before the increment, capture first_err_addr/first_err_data.
- DRAIN: chipselect=0; wait until the compare pipeline is empty, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start in that cycle is ignored.
- Status hold: err_count and first_err_* hold until the next accepted start.
- Reset mid-operation: chipselect/write drop immediately (async); pipeline flushed; no done pulse.
- Latency:
  - FILL of N words: first access the cycle after start; done asserted N+1 cycles after the start edge.
  - VERIFY of N words: done asserted N+READ_LATENCY+1 cycles after the start edge.

Test Plan:
- FILL base=0x0010, len=4, seed=0xA5A50000 -> writes at 0x0010..0x0013 with data 0xA5A50000..0xA5A50003 on 4 consecutive cycles, byteenable=0xF; done pulse 5 cycles after start.
- VERIFY of the same range against a behavioural 1-cycle-latency memory model -> 4 reads, err_count=0, done 6 cycles after start.
- Corrupt model word 0x0012 to 0 and repeat VERIFY -> err_count=1, first_err_addr=0x0012, first_err_data=0x00000000.
- length=0 with start -> chipselect never asserted; done pulses; err_count=0.
- FILL base=0xFFFE, len=3, seed=0xFFFFFFFF -> addresses 0xFFFE, 0xFFFF, 0x0000 with data 0xFFFFFFFF, 0x00000000, 0x00000001.
- Assert reset during cycle 2 of a 10-word VERIFY -> chipselect=0 and busy=0 without a clock edge; no done pulse. A second start pulse during a run is ignored (address sequence unchanged).
